// File: rtl/jogo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jogo_pkg
//  Description : Shared types and constants for the jogo da velha datapath
//                (keypad decoder state codes, board size, "no move" marker).
//  Revision    : 1.0 - initial release
// ============================================================================
package jogo_pkg;

    localparam int N_BOTOES = 9;
    localparam logic [3:0] JOGADA_NENHUMA = 4'hF;

    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        CONTANDO      = 3'd1,
        VALIDA        = 3'd2,
        ESPERA_SOLTAR = 3'd3,
        ERRO          = 3'd4
    } estado_jogada_t;

endpackage
`default_nettype wire

// File: rtl/decodificador_jogada_if.sv
`default_nettype none
// ============================================================================
//  Module      : decodificador_jogada_if
//  Description : Keypad-to-controller bundle. The master side (controller /
//                keypad) drives habilita and botoes; the slave side (decoder)
//                returns the decoded move and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface decodificador_jogada_if;
    import jogo_pkg::*;

    logic                habilita;
    logic [N_BOTOES-1:0] botoes;
    logic [3:0]          jogada;
    logic                jogada_valida;
    logic                erro_multipla;
    logic                tem_jogada;
    logic [2:0]          db_estado;

    modport master (
        output habilita,
        output botoes,
        input  jogada,
        input  jogada_valida,
        input  erro_multipla,
        input  tem_jogada,
        input  db_estado
    );

    modport slave (
        input  habilita,
        input  botoes,
        output jogada,
        output jogada_valida,
        output erro_multipla,
        output tem_jogada,
        output db_estado
    );

endinterface
`default_nettype wire

// File: rtl/codificador_onehot.sv
`default_nettype none
// ============================================================================
//  Module      : codificador_onehot
//  Description : Combinational encoder for the button vector: returns the
//                index of the lowest set bit (JOGADA_NENHUMA if none) and
//                flags whether exactly one bit is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module codificador_onehot
    import jogo_pkg::*;
(
    input  wire logic [N_BOTOES-1:0] i_vetor,
    output logic      [3:0]          indice,
    output logic                     eh_onehot
);

    logic [3:0] w_contagem;

    // Scan from the top so the lowest set bit wins; count bits in parallel.
    always_comb begin
        indice     = JOGADA_NENHUMA;
        w_contagem = 4'd0;
        for (int i = N_BOTOES - 1; i >= 0; i--) begin
            if (i_vetor[i]) begin
                indice = 4'(i);
            end
            w_contagem = w_contagem + {3'b000, i_vetor[i]};
        end
        eh_onehot = (w_contagem == 4'd1);
    end

endmodule
`default_nettype wire

// File: rtl/decodificador_jogada.sv
`default_nettype none
// ============================================================================
//  Module      : decodificador_jogada
//  Description : Keypad front-end. Registers the raw buttons, requires a
//                press to stay stable for MIN_CICLOS cycles, then emits a
//                one-cycle move strobe (single button) or error strobe
//                (several buttons). A new press needs a full release first.
//  Revision    : 1.0 - initial release
// ============================================================================
module decodificador_jogada #(
    parameter int N_BOTOES   = 9,
    parameter int MIN_CICLOS = 2
) (
    input  wire logic              clock,
    input  wire logic              reset,
    decodificador_jogada_if.slave  bus
);
    import jogo_pkg::estado_jogada_t;
    import jogo_pkg::OCIOSO;
    import jogo_pkg::CONTANDO;
    import jogo_pkg::VALIDA;
    import jogo_pkg::ESPERA_SOLTAR;
    import jogo_pkg::ERRO;
    import jogo_pkg::JOGADA_NENHUMA;

    localparam logic [3:0] c_min_ciclos = 4'(MIN_CICLOS);

    estado_jogada_t      estado_q, estado_d;
    logic [N_BOTOES-1:0] botoes_r_q, botoes_r_d;
    logic [N_BOTOES-1:0] snap_q, snap_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          jogada_q, jogada_d;
    // High for the first cycle after reset: botoes_r still holds its reset
    // zero, which must not be mistaken for a release of a held button.
    logic                pos_reset_q, pos_reset_d;

    logic [3:0]          w_indice;
    logic                w_eh_onehot;

    codificador_onehot u_codificador (
        .i_vetor   (snap_q),
        .indice    (w_indice),
        .eh_onehot (w_eh_onehot)
    );

    // Next-state and datapath decisions, all taken on the registered buttons.
    always_comb begin
        botoes_r_d  = bus.botoes;
        snap_d      = snap_q;
        cnt_d       = cnt_q;
        jogada_d    = jogada_q;
        estado_d    = estado_q;
        pos_reset_d = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (bus.habilita && (botoes_r_q != '0)) begin
                    snap_d   = botoes_r_q;
                    cnt_d    = 4'd1;
                    estado_d = CONTANDO;
                end
            end
            CONTANDO: begin
                if (!bus.habilita) begin
                    estado_d = ESPERA_SOLTAR;
                end else if (botoes_r_q == '0) begin
                    estado_d = OCIOSO;
                end else if (botoes_r_q != snap_q) begin
                    snap_d = botoes_r_q;
                    cnt_d  = 4'd1;
                end else if ((cnt_q + 4'd1) == c_min_ciclos) begin
                    if (w_eh_onehot) begin
                        jogada_d = w_indice;
                        estado_d = VALIDA;
                    end else begin
                        estado_d = ERRO;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            VALIDA: begin
                estado_d = ESPERA_SOLTAR;
            end
            ERRO: begin
                estado_d = ESPERA_SOLTAR;
            end
            ESPERA_SOLTAR: begin
                if (!pos_reset_q && (botoes_r_q == '0)) begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = ESPERA_SOLTAR;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= ESPERA_SOLTAR;
            botoes_r_q  <= '0;
            snap_q      <= '0;
            cnt_q       <= 4'd0;
            jogada_q    <= JOGADA_NENHUMA;
            pos_reset_q <= 1'b1;
        end else begin
            estado_q    <= estado_d;
            botoes_r_q  <= botoes_r_d;
            snap_q      <= snap_d;
            cnt_q       <= cnt_d;
            jogada_q    <= jogada_d;
            pos_reset_q <= pos_reset_d;
        end
    end

    // Outputs come straight from registers or from the state decode.
    assign bus.jogada        = jogada_q;
    assign bus.jogada_valida = (estado_q == VALIDA);
    assign bus.erro_multipla = (estado_q == ERRO);
    assign bus.tem_jogada    = |botoes_r_q;
    assign bus.db_estado     = estado_q;

endmodule
`default_nettype wire

// File: doc/decodificador_jogada.md
# decodificador_jogada

Front-end receiver for the player's 9-button keypad of the jogo da velha board. It registers the raw `botoes` vector and requires each press to stay stable for a minimum number of cycles. A press of exactly one button becomes a one-cycle `jogada_valida` strobe carrying the cell index 0..8. A multi-button press is rejected with an error pulse, and a new press is accepted only after all buttons are released. The game control unit consumes its output for both macro and micro moves.

## Interface
Parameters:
- `N_BOTOES`, default 9: number of buttons/cells; fixed at 9 for this design.
- `MIN_CICLOS`, default 2: number of consecutive cycles a press must be stable; legal range 2..15.

Ports:
- `clock`, in, 1: single system clock.
- `reset`, in, 1: synchronous, active-high.
- `habilita`, in, 1: high while the controller accepts a move; sampled only in OCIOSO and CONTANDO.
- `botoes`, in, 9: raw buttons, active-high; bit i corresponds to cell i.
- `jogada`, out, 4: index of the last valid move (0..8); 4'hF means none since reset.
- `jogada_valida`, out, 1: one-cycle strobe; `jogada` is already valid in the same cycle.
- `erro_multipla`, out, 1: one-cycle strobe when a stable press has more than one bit set.
- `tem_jogada`, out, 1: OR of the registered button vector (debug/LED).
- `db_estado`, out, 3: current FSM state code.

## Operation
- Input register `botoes_r` samples `botoes` every cycle. All FSM decisions use `botoes_r`, never raw `botoes`.
- OCIOSO (0): if `habilita` and `botoes_r != 0`, load `snap <= botoes_r`, set `cnt <= 1`, and go to CONTANDO. Otherwise stay.
- CONTANDO (1), evaluated in this priority order:
  - `habilita` low → ESPERA_SOLTAR, with no strobe.
  - `botoes_r == 0` → OCIOSO (press too short, discarded).
  - `botoes_r != snap` → reload `snap <= botoes_r`, set `cnt <= 1`, stay.
  - Match and `cnt + 1 == MIN_CICLOS` → VALIDA if `snap` is one-hot, else ERRO.
  - Match otherwise → `cnt <= cnt + 1`.
- VALIDA (2): `jogada_valida = 1` and `jogada <= index(snap)`, then go to ESPERA_SOLTAR.
- ERRO (4): `erro_multipla = 1`, `jogada` unchanged, then go to ESPERA_SOLTAR.
- ESPERA_SOLTAR (3): stay until `botoes_r == 0`, then go to OCIOSO. This holds regardless of `habilita`.
- Counter width is 4 bits and never wraps, because the legal range of `MIN_CICLOS` is ≤15.
- Changing which button is held mid-count restarts the count. Holding the same button after a strobe produces no second strobe.

## Timing
- Reset values:
  - FSM state is ESPERA_SOLTAR, so a button held across reset is never accepted.
  - `botoes_r = 0`, `snap = 0`, `cnt = 0`.
  - `jogada = 4'hF`, `jogada_valida = 0`, `erro_multipla = 0`.
  - `tem_jogada = 0`, `db_estado = 3`.
- Reset asserted mid-operation aborts at once: no pending strobe is emitted.
- Latency, with `MIN_CICLOS = 2` and a press first sampled into `botoes_r` at edge k:
  - FSM enters CONTANDO at k+1 and VALIDA at k+2.
  - `jogada_valida` is high for the cycle between edges k+2 and k+3.
  - A press held for exactly `MIN_CICLOS` clock edges is therefore accepted.
  - A press held for `MIN_CICLOS − 1` edges is discarded.
- `jogada` updates on the same edge that raises `jogada_valida` and holds until the next VALIDA.
- `jogada_valida` and `erro_multipla` are never high together.
- `tem_jogada` follows `botoes_r`, i.e. one cycle after `botoes`.
- All outputs are registered or decoded directly from state; no combinational path runs from `botoes` to any output.

## Structure
- The shared package `jogo_pkg` holds:
  - the state enum `estado_jogada_t` (OCIOSO = 0, CONTANDO = 1, VALIDA = 2, ESPERA_SOLTAR = 3, ERRO = 4);
  - `N_BOTOES = 9`;
  - `JOGADA_NENHUMA = 4'hF`.
- One combinational sub-module, `codificador_onehot`: 9-bit in; outputs `indice[3:0]` and `eh_onehot`. It is reusable by the LED/display path.

## Test plan
- Reset, then `habilita = 1` and `botoes = 9'b000001000` held 2 cycles → one `jogada_valida` pulse with `jogada = 3`, then back to OCIOSO after release.
- `botoes = 9'b000010000` held 20 cycles → exactly one strobe with `jogada = 4`; state stays at 3 until release.
- `botoes = 9'b000000010` held 1 cycle → no strobe; `jogada` keeps its previous value.
- `botoes = 9'b000000011` held 3 cycles → one `erro_multipla` pulse, no `jogada_valida`, `jogada` unchanged.
- `habilita = 0` with `botoes = 9'b100000000` held 5 cycles → no strobe. Then raise `habilita` while the button is still held → the press is accepted, with `jogada = 8`, 2 cycles after `habilita` rises.
- Hold `botoes = 9'b000000001` and pulse `reset` mid-count → no strobe, `jogada = 4'hF`, state 3 until release; a subsequent clean press gives `jogada = 0`.
